// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame states,
// prefix byte values and the layout of one decoded FIFO entry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_entry_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stable-sample filter for one PS/2 line.
// The filtered output only follows the input after DEBOUNCE_CYCLES agreeing samples.
module ps2_line_filter #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            dout       <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // Any sample that agrees with the current output restarts the count.
            if (sync_p1 == dout) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dout       <= sync_p1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered lines, frame FSM with timeout, E0/F0 prefix
// decoding and a keycode FIFO. Define PS2_PARITY_CHECK_EN to enable odd-parity rejection.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          kclk,
    input  logic                          kdata,
    output logic [15:0]                   keycode,
    output logic                          key_release,
    output logic                          keycode_valid,
    input  logic                          keycode_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic kclk_f;
    logic kdata_f;

    ps2_line_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kclk_filter (
        .clk    (clk),
        .resetn (resetn),
        .din    (kclk),
        .dout   (kclk_f)
    );

    ps2_line_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kdata_filter (
        .clk    (clk),
        .resetn (resetn),
        .din    (kdata),
        .dout   (kdata_f)
    );

    // Stage p0: falling-edge strobe of the filtered PS/2 clock
    logic kclk_f_q;
    logic fall_p0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            kclk_f_q <= 1'b1;
            fall_p0  <= 1'b0;
        end else begin
            kclk_f_q <= kclk_f;
            fall_p0  <= kclk_f_q & ~kclk_f;
        end
    end

    frame_state_t  state;
    frame_state_t  state_nxt;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift;
    logic          parity_fail;
    logic          timeout;
    logic          frame_bad;
    logic          parity_bad;
    logic          byte_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    assign parity_fail = ~(^shift ^ par_bit);
`else
    assign parity_fail = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        timeout    = 1'b0;
        frame_bad  = 1'b0;
        parity_bad = 1'b0;
        byte_ok    = 1'b0;
        if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end else if (fall_p0) begin
            case (state)
                IDLE:    if (!kdata_f) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (!kdata_f)         frame_bad  = 1'b1;
                    else if (parity_fail) parity_bad = 1'b1;
                    else                  byte_ok    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (fall_p0 || state == IDLE || timeout) to_cnt <= '0;
            else                                     to_cnt <= to_cnt + 1'b1;
            if (timeout || state != DATA)            bit_cnt <= '0;
            else if (fall_p0)                        bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (timeout)                       shift <= '0;
        else if (fall_p0 && state == DATA) shift <= {kdata_f, shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
        if (fall_p0 && state == PARITY)    par_bit <= kdata_f;
`endif
    end

    // Stage p1: completed byte and registered error pulses
    logic       vld_p1;
    logic [7:0] byte_p1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vld_p1     <= byte_ok;
            parity_err <= parity_bad;
            frame_err  <= frame_bad | timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_ok) byte_p1 <= shift;
    end

    // Stage p2: prefix decode and FIFO write
    logic       ext;
    logic       brk;
    logic       push;
    key_entry_t entry_in;

    always_comb begin
        entry_in = '{ext: ext, brk: brk, code: byte_p1};
        push     = vld_p1 && byte_p1 != PS2_EXT_CODE && byte_p1 != PS2_BRK_CODE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (parity_bad || frame_bad || timeout) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (vld_p1) begin
            if (byte_p1 == PS2_EXT_CODE) begin
                ext <= 1'b1;
            end else if (byte_p1 == PS2_BRK_CODE) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    key_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    key_entry_t    head;

    assign full          = (count == (AW+1)'(FIFO_DEPTH));
    assign keycode_valid = (count != '0);
    assign pop           = keycode_valid & keycode_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en         = push & (~full | pop);
    assign head          = mem[rd_ptr];
    assign keycode       = keycode_valid ? {(head.ext ? PS2_EXT_CODE : 8'h00), head.code} : 16'h0000;
    assign key_release   = keycode_valid & head.brk;
    assign fifo_level    = count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~pop;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= entry_in;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Fully synchronous PS/2 keyboard receiver with odd-parity checking, frame/timeout recovery, E0/F0 prefix decoding and a parametrised output FIFO. Sits between the board PS/2 pins and the peripheral bus controller. The controller drains decoded keycodes through a valid/ready handshake, so no keystrokes are lost while the CPU is busy. All logic runs on the system clock; PS/2 clock edges are detected, never used as a clock.

## Interface
- DEBOUNCE_CYCLES, 20, consecutive stable `clk` samples required before a filtered line changes
- TIMEOUT_CYCLES, 100000, maximum `clk` cycles between falling kclk edges inside a frame
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥2
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous reset, active-low
- kclk  input  1  raw PS/2 clock pin, asynchronous
- kdata  input  1  raw PS/2 data pin, asynchronous
- keycode  output  16  head entry: {8'hE0 if extended else 8'h00, scan code}
- key_release  output  1  head entry was preceded by F0 (break code)
- keycode_valid  output  1  FIFO not empty
- keycode_ready  input  1  consumer pops head when high with keycode_valid
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count
- parity_err  output  1  one-cycle pulse, byte discarded on bad parity
- frame_err  output  1  one-cycle pulse, bad stop bit or timeout
- overflow  output  1  one-cycle pulse, decoded key dropped because FIFO full

## Operation
- Input path: 2-FF synchroniser per line, then a stable-count filter. Synchroniser and filtered outputs reset to 1 (idle bus).
- Edge detect: `fall` = filtered kclk 1→0, registered. One cycle per PS/2 clock edge.
- Frame FSM, advancing only on `fall`:
  - IDLE: kdata=0 → DATA; kdata=1 → stay (spurious edge ignored).
  - DATA: shift kdata in LSB-first; after 8 bits → PARITY.
  - PARITY: sample bit → STOP.
  - STOP: kdata=1 → byte done, return to IDLE; kdata=0 → frame_err, byte discarded, IDLE.
- Timeout: counter clears on every `fall`. When not in IDLE and the counter reaches TIMEOUT_CYCLES → frame_err, IDLE, partial byte and prefix flags cleared.
- Decoder, on byte done:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte pushes {ext, brk, code} and clears both flags.
  - Prefixes are never pushed.
- Rejected bytes (parity, frame, timeout) also clear `ext`/`brk`.
- FIFO: circular buffer with wrap-around pointers.
  - Push when full → entry dropped, overflow pulse.
  - Push and pop in the same cycle when full → both happen, no overflow.
  - Push and pop in the same cycle when empty → not possible; push only, head visible the next cycle.
  - Pop when empty → no effect.
- Reset (any time, including mid-frame): FSM IDLE, flags and counters 0, FIFO empty. keycode=0, key_release=0, keycode_valid=0, fifo_level=0, all error pulses 0.

## Timing
- Filter latency: DEBOUNCE_CYCLES+2 cycles from pin change to filtered change.
- Stop-bit `fall` cycle N: byte done registered at N+1, FIFO write at N+2, keycode_valid high at N+2 if previously empty.
- Error pulses assert exactly one cycle, in the cycle following the detecting `fall` or timeout.
- keycode/key_release stable while keycode_valid=1 and keycode_ready=0.
- Throughput: one pop per cycle.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - Odd parity checked: XOR of 8 data bits and parity bit must be 1.
  - On mismatch: parity_err pulse, byte discarded, prefix flags cleared.
- PS2_PARITY_CHECK_EN undefined: parity bit sampled and ignored, parity_err tied 0.

## Structure
- Package ps2_pkg:
  - frame state enum (IDLE, DATA, PARITY, STOP)
  - localparams PS2_EXT_CODE=8'hE0, PS2_BRK_CODE=8'hF0
  - packed struct for the FIFO entry (ext, brk, code[7:0])
- Sub-module ps2_line_filter: 2-FF synchroniser plus stable counter, parameter DEBOUNCE_CYCLES. Instantiated once per line (kclk, kdata).

## Test plan
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), ready=1 → keycode=16'h001C, key_release=0, one valid cycle, no errors.
- Frames E0, F0, 75 → one entry keycode=16'hE075, key_release=1; prefixes not visible.
- Frame 0x1C with parity 1 → parity_err pulse, no entry. Repeat without PS2_PARITY_CHECK_EN → entry 16'h001C pushed.
- kclk stops after 4 data bits for TIMEOUT_CYCLES → frame_err pulse, FSM IDLE; next valid frame 0x32 → keycode=16'h0032.
- ready=0, send FIFO_DEPTH+1 keys → fifo_level=FIFO_DEPTH, one overflow pulse. Drain with ready=1 → first FIFO_DEPTH codes in order, then valid=0.
- Assert resetn=0 mid-DATA for one cycle → outputs 0, FIFO empty; following frame 0x1C received correctly.
